// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle ARM-subset control FSM with condition flags and memory handshake
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;
    state_t state;
    logic [3:0] flags;
    logic [3:0] cmd;
    logic n, z, c, v, condex, condex_q, addsub;
    logic regw, branch, aluop, memreq, memwrite, irwrite;
    assign {n, z, c, v} = flags;
    assign cmd = Funct[4:1];
    assign addsub = (cmd == 4'b0100) || (cmd == 4'b0010);
    always_comb begin
        condex = 1'b0;
        case (Cond)
            4'd0:  condex = z;
            4'd1:  condex = !z;
            4'd2:  condex = c;
            4'd3:  condex = !c;
            4'd4:  condex = n;
            4'd5:  condex = !n;
            4'd6:  condex = v;
            4'd7:  condex = !v;
            4'd8:  condex = c && !z;
            4'd9:  condex = !c || z;
            4'd10: condex = n == v;
            4'd11: condex = n != v;
            4'd12: condex = !z && (n == v);
            4'd13: condex = z || (n != v);
            4'd14: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            flags    <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    condex_q <= condex;
                    state <= Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH :
                             Op == 2'b11 ? FETCH : Funct[5] ? EXECI : EXECR;
                end
                MEMADR:   state <= Funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWRITE: if (!condex_q || mem_ready) state <= FETCH;
                EXECR, EXECI: begin
                    state <= ALUWB;
                    if (Funct[0] && condex_q) begin
                        flags[3:2] <= ALUFlags[3:2];
                        if (addsub) flags[1:0] <= ALUFlags[1:0];
                    end
                end
                default:  state <= FETCH;
            endcase
        end
    end
    always_comb begin
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        regw      = 1'b0;
        branch    = 1'b0;
        aluop     = 1'b0;
        memreq    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                memreq    = 1'b1;
                irwrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD: begin
                AdrSrc = 1'b1;
                memreq = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = condex_q;
                memreq   = condex_q;
                memwrite = condex_q;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            EXECR:    aluop = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                aluop   = 1'b1;
            end
            ALUWB:    regw = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end
    assign PCWrite  = !reset && (state == FETCH ? mem_ready : condex_q && (branch || (regw && Rd == 4'hF)));
    assign IRWrite  = !reset && irwrite;
    assign RegWrite = !reset && regw && condex_q;
    assign MemWrite = !reset && memwrite;
    assign MemReq   = !reset && memreq;
    assign ALUControl = !aluop ? 2'b00 : cmd == 4'b0100 ? 2'b00 : cmd == 4'b0010 ? 2'b01 :
                        cmd == 4'b0000 ? 2'b10 : cmd == 4'b1100 ? 2'b11 : 2'b00;
    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = state;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Cond  in  4  instruction condition field.
REQ-005 Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch.
REQ-006 Funct  in  6  Funct[5]=I (immediate), Funct[4:1]=cmd, Funct[0]=S or L.
REQ-007 Rd  in  4  destination register index.
REQ-008 ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-009 mem_ready  in  1  memory completes the current request this cycle.
REQ-010 Outputs SHALL be PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc, ALUSrcA (each 1 bit); ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc (each 2 bits); State (4 bits, debug).

Function
REQ-011 The FSM SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; any other code SHALL go to FETCH on the next edge.
REQ-012 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, MemReq=1; IRWrite and PCWrite SHALL equal mem_ready; the FSM SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-013 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; condex_q SHALL be loaded with CondEx (REQ-021).
REQ-014 DECODE next state: Op=01 -> MEMADR; Op=00 with Funct[5]=1 -> EXECI; Op=00 with Funct[5]=0 -> EXECR; Op=10 -> BRANCH; Op=11 -> FETCH (NOP).
REQ-015 MEMADR: ALUSrcA=0, ALUSrcB=01, ALU add; next state SHALL be MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00, MemReq=1; the FSM SHALL hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWRITE with condex_q=1: AdrSrc=1, MemReq=1, MemWrite=1 held until mem_ready=1, then FETCH; with condex_q=0, MemReq=MemWrite=0 and the next state SHALL be FETCH.
REQ-018 MEMWB: ResultSrc=01, RegW=1. ALUWB: ResultSrc=00, RegW=1. Both SHALL go to FETCH next.
REQ-019 EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1. EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Both SHALL go to ALUWB next.
REQ-020 BRANCH: ALUSrcA=0, ALUSrcB=01, ALU add, ResultSrc=10, Branch=1; next state SHALL be FETCH.
REQ-021 CondEx SHALL be computed from Cond and the stored flags {N,Z,C,V}: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 -> 0.
REQ-022 Gating: RegWrite SHALL be RegW & condex_q; PCWrite (outside FETCH) SHALL be condex_q & (Branch | (RegW & Rd==15)).
REQ-023 ALUControl: ALUOp=0 -> 00 (add); ALUOp=1 decodes cmd: 0100 -> 00 ADD, 0010 -> 01 SUB, 0000 -> 10 AND, 1100 -> 11 ORR, any other cmd -> 00.
REQ-024 Flag update: in EXECR/EXECI, when Funct[0]=1 and condex_q=1, flags SHALL load from ALUFlags on the edge: N,Z for all cmds; C,V only for ADD/SUB.
REQ-025 ImmSrc SHALL equal Op; RegSrc[0] SHALL be (Op==10); RegSrc[1] SHALL be (Op==01).
REQ-026 Every unlisted write enable SHALL be 0 in each state; unlisted muxes SHALL be 0.
REQ-027 State SHALL output the current state code.

Reset
REQ-028 While reset=1, on each edge state SHALL become FETCH, flags SHALL become 0000 and condex_q SHALL become 0; this applies mid-instruction, including mid-MEMWRITE.
REQ-029 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and MemReq SHALL be forced to 0 regardless of state or mem_ready.

Verification
REQ-030 ADD register (Cond=1110, Op=00, Funct=001000, Rd=3), mem_ready=1 -> states 0,1,6,8,0; ALUControl=00; RegWrite=1 only in ALUWB.
REQ-031 SUBS immediate (Funct=100101) with ALUFlags=0100, then BEQ (Cond=0000, Op=10) -> Z=1 after EXECI; PCWrite=1 in BRANCH. Repeat with ALUFlags=0000 -> PCWrite=0 in BRANCH.
REQ-032 LDR (Op=01, Funct[0]=1) with mem_ready low for 3 cycles in MEMREAD -> 3 cycles held in state 3; MemReq=1 throughout; MEMWB follows.
REQ-033 STR with condex_q=0 (Cond=0001, Z=1) -> MEMADR then FETCH; MemWrite=0 and MemReq=0 in MEMWRITE.
REQ-034 ORR with Rd=15 -> PCWrite=RegWrite=1 in ALUWB. Op=11 -> DECODE to FETCH with no enables asserted.
REQ-035 Reset asserted in MEMWRITE while mem_ready=0 -> MemWrite=0 in the same cycle; State=0 and flags=0000 after the edge.
